rcas: RTL and testbench

- Parameterised ripple-carry adder/subtractor built from a generate chain of 1-bit full adders, with a registered result stage.
- The operation (add or subtract) is fixed at elaboration by parameter mode.
- Used as a datapath arithmetic leaf. Inputs are sampled every clock; the result appears one cycle later with a valid flag.

---
 rtl/rcas_pkg.sv | 13 +
 rtl/rcas_fa.sv | 15 +
 rtl/rcas.sv | 71 +++++++
 tb/tb_rcas.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/rcas_pkg.sv
// Shared constants and helpers for the ripple-carry adder/subtractor.
package rcas_pkg;

    localparam int MODE_SUB   = 0;
    localparam int MODE_ADD   = 1;
    localparam int RCAS_WIDTH = 32;

    // Majority of three bits, i.e. the carry-out of a full adder.
    function automatic logic maj3(input logic x, input logic y, input logic z);
        return (x & y) | (x & z) | (y & z);
    endfunction

endpackage

// File: rtl/rcas_fa.sv
// One-bit full adder: the repeated stage of the ripple chain.
module fa
    import rcas_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = maj3(a, b, cin);

endmodule

// File: rtl/rcas.sv
// Ripple-carry adder/subtractor with a single registered result stage.
// The operation is fixed at elaboration; any mode other than MODE_ADD subtracts.
module rcas
    import rcas_pkg::*;
#(
    parameter int G    = RCAS_WIDTH,
    parameter int mode = MODE_SUB
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [G-1:0] a,
    input  logic [G-1:0] b,
    input  logic         cin,
    output logic         out_valid,
    output logic [G-1:0] sum,
    output logic         carry
);

    localparam logic INV_B = (mode != MODE_ADD);

    logic [G-1:0] b_eff;
    logic [G-1:0] s;
    logic [G:0]   c;

    logic [G-1:0] sum_q,   sum_d;
    logic         carry_q, carry_d;
    logic         valid_q, valid_d;

    // Subtraction is a + ~b + cin, so b is inverted ahead of the chain.
    assign b_eff = b ^ {G{INV_B}};
    assign c[0]  = cin;

    genvar i;
    generate
        for (i = 0; i < G; i++) begin : g_stage
            fa u_fa (
                .a    (a[i]),
                .b    (b_eff[i]),
                .cin  (c[i]),
                .s    (s[i]),
                .cout (c[i+1])
            );
        end
    endgenerate

    // Capture a new result only on valid cycles; otherwise hold the last one.
    always_comb begin
        valid_d = in_valid;
        sum_d   = in_valid ? s    : sum_q;
        carry_d = in_valid ? c[G] : carry_q;
    end

    // Result register, cleared immediately by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q   <= '0;
            carry_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            sum_q   <= sum_d;
            carry_q <= carry_d;
            valid_q <= valid_d;
        end
    end

    assign out_valid = valid_q;
    assign sum       = sum_q;
    assign carry     = carry_q;

endmodule

// File: tb/tb_rcas.sv
// Directed + randomised check of rcas in both adder and subtractor builds.
module tb_rcas;

    localparam int W = 32;

    typedef struct packed {
        logic         v;
        logic [W-1:0] s;
        logic         c;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic         add_vi = 1'b0, add_cin = 1'b0;
    logic [W-1:0] add_a = '0, add_b = '0;
    logic         add_vo, add_co;
    logic [W-1:0] add_sum;

    logic         sub_vi = 1'b0, sub_cin = 1'b0;
    logic [W-1:0] sub_a = '0, sub_b = '0;
    logic         sub_vo, sub_co;
    logic [W-1:0] sub_sum;

    exp_t q_add[$];
    exp_t q_sub[$];
    logic [W-1:0] hold_s_add = '0, hold_s_sub = '0;
    logic         hold_c_add = 1'b0, hold_c_sub = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rcas #(.G(W), .mode(1)) u_add (
        .clk(clk), .rst(rst), .in_valid(add_vi), .a(add_a), .b(add_b), .cin(add_cin),
        .out_valid(add_vo), .sum(add_sum), .carry(add_co)
    );

    rcas #(.G(W), .mode(0)) u_sub (
        .clk(clk), .rst(rst), .in_valid(sub_vi), .a(sub_a), .b(sub_b), .cin(sub_cin),
        .out_valid(sub_vo), .sum(sub_sum), .carry(sub_co)
    );

    function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
        return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
    endfunction

    function automatic logic [W:0] ref_sub(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
        logic [W-1:0] ny;
        ny = ~y;
        return {1'b0, x} + {1'b0, ny} + {{W{1'b0}}, ci};
    endfunction

    task automatic chk(input string tag, input logic [W:0] got, input logic [W:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic drive_add(input logic v, input logic [W-1:0] x, input logic [W-1:0] y,
                             input logic ci, input logic [W-1:0] es, input logic ec);
        exp_t e;
        add_vi = v; add_a = x; add_b = y; add_cin = ci;
        if (v) begin
            hold_s_add = es;
            hold_c_add = ec;
        end
        e.v = v; e.s = hold_s_add; e.c = hold_c_add;
        q_add.push_back(e);
    endtask

    task automatic drive_sub(input logic v, input logic [W-1:0] x, input logic [W-1:0] y,
                             input logic ci, input logic [W-1:0] es, input logic ec);
        exp_t e;
        sub_vi = v; sub_a = x; sub_b = y; sub_cin = ci;
        if (v) begin
            hold_s_sub = es;
            hold_c_sub = ec;
        end
        e.v = v; e.s = hold_s_sub; e.c = hold_c_sub;
        q_sub.push_back(e);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_add_valid"}, {{W{1'b0}}, add_vo}, '0);
        chk({tag, "_add_sum"},   {1'b0, add_sum},     '0);
        chk({tag, "_add_carry"}, {{W{1'b0}}, add_co}, '0);
        chk({tag, "_sub_valid"}, {{W{1'b0}}, sub_vo}, '0);
        chk({tag, "_sub_sum"},   {1'b0, sub_sum},     '0);
        chk({tag, "_sub_carry"}, {{W{1'b0}}, sub_co}, '0);
    endtask

    task automatic flush_model();
        q_add.delete();
        q_sub.delete();
        hold_s_add = '0; hold_c_add = 1'b0;
        hold_s_sub = '0; hold_c_sub = 1'b0;
    endtask

    // One clock: sample #1 after the edge and compare against the scoreboard heads.
    task automatic tick(input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        if (q_add.size() == 0) begin
            chk({tag, "_add_queue_empty"}, 1, 0);
        end else begin
            e = q_add.pop_front();
            chk({tag, "_add_valid"}, {{W{1'b0}}, add_vo}, {{W{1'b0}}, e.v});
            chk({tag, "_add_sum"},   {1'b0, add_sum},     {1'b0, e.s});
            chk({tag, "_add_carry"}, {{W{1'b0}}, add_co}, {{W{1'b0}}, e.c});
        end
        if (q_sub.size() == 0) begin
            chk({tag, "_sub_queue_empty"}, 1, 0);
        end else begin
            e = q_sub.pop_front();
            chk({tag, "_sub_valid"}, {{W{1'b0}}, sub_vo}, {{W{1'b0}}, e.v});
            chk({tag, "_sub_sum"},   {1'b0, sub_sum},     {1'b0, e.s});
            chk({tag, "_sub_carry"}, {{W{1'b0}}, sub_co}, {{W{1'b0}}, e.c});
        end
    endtask

    initial begin
        logic [W:0]   r;
        logic [W-1:0] ra, rb;
        logic         rc, rv;

        // Power-on reset
        #2;
        check_reset_state("por");
        @(posedge clk);
        #1;
        check_reset_state("por_edge");
        rst = 1'b0;
        flush_model();

        // Directed arithmetic and boundaries
        drive_add(1'b1, 32'd25, 32'd70, 1'b1, 32'd96, 1'b0);
        drive_sub(1'b1, 32'd100, 32'd30, 1'b1, 32'd70, 1'b1);
        tick("d0");
        drive_add(1'b1, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'd0, 1'b1);
        drive_sub(1'b1, 32'd40, 32'd40, 1'b1, 32'd0, 1'b1);
        tick("d1");
        drive_add(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1);
        drive_sub(1'b1, 32'd40, 32'd10, 1'b0, 32'd29, 1'b1);
        tick("d2");
        drive_add(1'b0, $urandom, $urandom, 1'b1, '0, 1'b0);
        drive_sub(1'b1, 32'd5, 32'd9, 1'b1, 32'hFFFF_FFFC, 1'b0);
        tick("d3");
        drive_add(1'b1, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0);
        drive_sub(1'b1, 32'd0, 32'd1, 1'b1, 32'hFFFF_FFFF, 1'b0);
        tick("d4");

        // Valid gating: random and unknown operands must not disturb held results
        drive_add(1'b0, $urandom, $urandom, 1'b1, '0, 1'b0);
        drive_sub(1'b0, $urandom, $urandom, 1'b0, '0, 1'b0);
        tick("idle0");
        drive_add(1'b0, 'x, 'x, 1'bx, '0, 1'b0);
        drive_sub(1'b0, 'x, 'x, 1'bx, '0, 1'b0);
        tick("idle1");

        // Asynchronous reset between edges with an operation in flight
        drive_add(1'b1, 32'd1000, 32'd2000, 1'b0, 32'd3000, 1'b0);
        drive_sub(1'b1, 32'd50, 32'd20, 1'b1, 32'd30, 1'b1);
        #1;
        rst = 1'b1;
        #1;
        check_reset_state("arst_now");
        flush_model();
        @(posedge clk);
        #1;
        check_reset_state("arst_edge");
        #2;
        rst = 1'b0;
        drive_add(1'b1, 32'd7, 32'd8, 1'b0, 32'd15, 1'b0);
        drive_sub(1'b1, 32'd9, 32'd5, 1'b1, 32'd4, 1'b1);
        tick("post_rst");

        // Randomised vectors against the (W+1)-bit reference, with some idle cycles
        for (int i = 0; i < 16; i++) begin
            rv = (i % 4) != 3;
            ra = $urandom_range(100, 0);
            rb = $urandom_range(100, 0);
            rc = 1'($urandom_range(1, 0));
            r  = ref_add(ra, rb, rc);
            drive_add(rv, ra, rb, rc, r[W-1:0], r[W]);
            ra = $urandom_range(100, 40);
            rb = $urandom_range(30, 0);
            r  = ref_sub(ra, rb, 1'b1);
            drive_sub(rv, ra, rb, 1'b1, r[W-1:0], r[W]);
            tick("rand");
        end

        drive_add(1'b0, '0, '0, 1'b0, '0, 1'b0);
        drive_sub(1'b0, '0, '0, 1'b0, '0, 1'b0);
        tick("drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
